// File: rtl/ext_frame_display_reader.sv
// Reads the QCIF 4:2:0 frame (Y, then Cb, then Cr) out of the external frame RAM as a byte stream with line and frame markers.
// Building with DISPLAY_CHECKSUM_EN adds a wrap-around byte-sum checksum of the emitted frame.
module ext_frame_display_reader #(
  parameter int ADDR_W       = 14,
  parameter int FRAME_WORDS  = 9504,
  parameter int CB_BASE      = 6336,
  parameter int CR_BASE      = 7920,
  parameter int Y_LINE_WORDS = 44,
  parameter int C_LINE_WORDS = 22,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ext_frame_RAM0_cs_n,
  output logic              ext_frame_RAM0_wr,
  output logic [ADDR_W-1:0] ext_frame_RAM0_addr,
  input  logic [31:0]       ext_frame_RAM0_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [7:0]        pix_data,
  output logic [1:0]        pix_plane,
  output logic              pix_sol,
  output logic              pix_eof,
  output logic [31:0]       checksum
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int COL_W = $clog2(Y_LINE_WORDS + 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              in_flight_q, in_flight_d;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [31:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0] head_idx_q, head_idx_d;
  logic [COL_W-1:0]  col_q, col_d;

  logic [CNT_W-1:0]  occupancy;
  logic              issue;
  logic              push;
  logic              pop;
  logic              hs;
  logic [31:0]       head_word;
  logic [ADDR_W-1:0] next_head;
  logic              line_last;

  // Reads in flight count against the FIFO so a full buffer can never be overrun.
  assign occupancy = count_q + CNT_W'(in_flight_q);
  assign issue     = (state_q == FETCH) && (occupancy < CNT_W'(FIFO_DEPTH));
  assign push      = in_flight_q;
  assign hs        = pix_valid && pix_ready;
  assign pop       = hs && (byte_idx_q == 2'd3);
  assign head_word = mem_q[rd_ptr_q];
  assign next_head = head_idx_q + ADDR_W'(1);

  assign busy                = (state_q != IDLE);
  assign done                = (state_q == FINISH);
  assign ext_frame_RAM0_cs_n = ~issue;
  assign ext_frame_RAM0_wr   = 1'b0;
  assign ext_frame_RAM0_addr = addr_q;

  assign pix_valid = (count_q != '0);
  assign pix_data  = pix_valid ? head_word[{byte_idx_q, 3'b000} +: 8] : 8'd0;
  assign pix_sol   = pix_valid && (byte_idx_q == 2'd0) && (col_q == '0);
  assign pix_eof   = pix_valid && (byte_idx_q == 2'd3) && (head_idx_q == LAST_WORD);

  always_comb begin
    pix_plane = 2'd2;
    if (head_idx_q < ADDR_W'(CB_BASE)) begin
      pix_plane = 2'd0;
    end else if (head_idx_q < ADDR_W'(CR_BASE)) begin
      pix_plane = 2'd1;
    end
  end

  assign line_last = (pix_plane == 2'd0) ? (col_q == COL_W'(Y_LINE_WORDS - 1))
                                         : (col_q == COL_W'(C_LINE_WORDS - 1));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    in_flight_d = issue;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    byte_idx_d  = byte_idx_q;
    head_idx_d  = head_idx_q;
    col_d       = col_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          addr_d     = '0;
          byte_idx_d = '0;
          head_idx_d = '0;
          col_d      = '0;
        end
      end
      FETCH:   if (issue && (addr_q == LAST_WORD)) state_d = DRAIN;
      DRAIN:   if (hs && pix_eof) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      addr_d = (addr_q == LAST_WORD) ? '0 : addr_q + ADDR_W'(1);
    end

    if (push) begin
      mem_d[wr_ptr_q] = ext_frame_RAM0_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (hs) begin
      byte_idx_d = byte_idx_q + 2'd1;
    end

    // Line column restarts at each plane base as well as at each line end.
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      head_idx_d = next_head;
      if ((next_head == ADDR_W'(CB_BASE)) || (next_head == ADDR_W'(CR_BASE)) || line_last) begin
        col_d = '0;
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      in_flight_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      byte_idx_q  <= '0;
      head_idx_q  <= '0;
      col_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      in_flight_q <= in_flight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      byte_idx_q  <= byte_idx_d;
      head_idx_q  <= head_idx_d;
      col_q       <= col_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef DISPLAY_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if ((state_q == IDLE) && start) begin
      checksum_d = '0;
    end else if (hs) begin
      checksum_d = checksum_q + {24'd0, pix_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_ext_frame_display_reader.sv
// Scoreboard bench for ext_frame_display_reader: a frame-level byte model feeds a queue that a negedge monitor drains.
`timescale 1ns/1ps
module tb_ext_frame_display_reader;

  localparam int ADDR_W      = 14;
  localparam int FRAME_WORDS = 9504;
  localparam int CB_BASE     = 6336;
  localparam int CR_BASE     = 7920;
  localparam int Y_LINE      = 44;
  localparam int C_LINE      = 22;
  localparam int DEPTH       = 4;
  localparam int FRAME_BYTES = FRAME_WORDS * 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              busy;
  logic              done;
  logic              cs_n;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       ram_q = 32'd0;
  logic              pix_valid;
  logic              pix_ready;
  logic [7:0]        pix_data;
  logic [1:0]        pix_plane;
  logic              pix_sol;
  logic              pix_eof;
  logic [31:0]       checksum;

  ext_frame_display_reader dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .busy                (busy),
    .done                (done),
    .ext_frame_RAM0_cs_n (cs_n),
    .ext_frame_RAM0_wr   (wr),
    .ext_frame_RAM0_addr (addr),
    .ext_frame_RAM0_data (ram_q),
    .pix_valid           (pix_valid),
    .pix_ready           (pix_ready),
    .pix_data            (pix_data),
    .pix_plane           (pix_plane),
    .pix_sol             (pix_sol),
    .pix_eof             (pix_eof),
    .checksum            (checksum)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [FRAME_WORDS];
  always @(posedge clk) if (!cs_n) ram_q <= mem[addr];

  int n_chk = 0;
  int n_err = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endfunction

  // Frame-level model: byte k belongs to word k/4, lane k%4; markers follow from plane and line geometry.
  function automatic logic [11:0] exp_byte(input int k);
    int w = k / 4;
    int b = k % 4;
    int base;
    int ll;
    logic [1:0] pl;
    logic [31:0] word;
    logic sol;
    logic eof;
    word = mem[w];
    if (w < CB_BASE) begin pl = 2'd0; base = 0; ll = Y_LINE; end
    else if (w < CR_BASE) begin pl = 2'd1; base = CB_BASE; ll = C_LINE; end
    else begin pl = 2'd2; base = CR_BASE; ll = C_LINE; end
    sol = (b == 0) && (((w - base) % ll) == 0);
    eof = (k == FRAME_BYTES - 1);
    return {word[8*b +: 8], pl, sol, eof};
  endfunction

  logic [11:0] sb_q [$];

  task automatic load_expect();
    for (int k = 0; k < FRAME_BYTES; k++) sb_q.push_back(exp_byte(k));
  endtask

  // Monitor state
  int          hs_count = 0;
  int          issued = 0;
  int          exp_addr = 0;
  int          done_count = 0;
  int          eof_count = 0;
  int          bubbles = 0;
  int          sol_cnt [3];
  int          first_idx [3];
  logic [31:0] byte_sum = 32'd0;
  logic [31:0] done_ck = 32'd0;
  logic        model_busy = 1'b0;
  logic        tp_mode = 1'b0;
  logic        stalled = 1'b0;
  logic [11:0] stall_val = 12'd0;

  always @(negedge clk) begin
    logic [11:0] cur;
    logic [11:0] e;
    cur = {pix_data, pix_plane, pix_sol, pix_eof};
    if (reset) begin
      sb_q.delete();
      model_busy = 1'b0;
      stalled    = 1'b0;
    end else begin
      if (start && !model_busy) begin
        model_busy = 1'b1;
        hs_count   = 0;
        issued     = 0;
        exp_addr   = 0;
        eof_count  = 0;
        bubbles    = 0;
        byte_sum   = 32'd0;
        sol_cnt    = '{0, 0, 0};
        first_idx  = '{-1, -1, -1};
      end
      if (!cs_n) begin
        check("rd_addr", 32'(addr), exp_addr);
        check("rd_wr", 32'(wr), 32'd0);
        check("rd_occupancy_below_depth", 32'((issued - hs_count / 4) < DEPTH), 32'd1);
        issued++;
        exp_addr++;
      end
      if (tp_mode && pix_ready && !pix_valid && model_busy && hs_count < FRAME_BYTES) bubbles++;
      if (pix_valid && pix_ready) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL sb_unexpected_byte: got 0x%0h expected no byte", pix_data);
        end else begin
          e = sb_q.pop_front();
          check("pix_byte{data,plane,sol,eof}", {20'd0, cur}, {20'd0, e});
        end
        if (pix_plane < 2'd3) begin
          if (first_idx[pix_plane] < 0) first_idx[pix_plane] = hs_count;
          if (pix_sol) sol_cnt[pix_plane]++;
        end
        if (pix_eof) eof_count++;
        byte_sum = byte_sum + {24'd0, pix_data};
        hs_count++;
      end
      if (stalled) check("stall_hold", {19'd0, pix_valid, cur}, {19'd0, 1'b1, stall_val});
      stalled   = pix_valid && !pix_ready;
      stall_val = cur;
      if (done) begin
        done_count++;
        done_ck    = checksum;
        model_busy = 1'b0;
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_done"},      32'(done), 0);
    check({tag, "_cs_n"},      32'(cs_n), 1);
    check({tag, "_wr"},        32'(wr), 0);
    check({tag, "_addr"},      32'(addr), 0);
    check({tag, "_pix_valid"}, 32'(pix_valid), 0);
    check({tag, "_pix_data"},  32'(pix_data), 0);
    check({tag, "_pix_plane"}, 32'(pix_plane), 0);
    check({tag, "_pix_sol"},   32'(pix_sol), 0);
    check({tag, "_pix_eof"},   32'(pix_eof), 0);
    check({tag, "_checksum"},  checksum, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cyc;
    int dc;
    bit got;
    bit restart_sent;
    logic [7:0] lo;
    logic [31:0] exp_sum;
    logic [31:0] w;

    reset = 1'b1;
    start = 1'b0;
    pix_ready = 1'b0;
    for (int i = 0; i < FRAME_WORDS; i++) begin
      lo = 8'(i);
      mem[i] = {lo + 8'd3, lo + 8'd2, lo + 8'd1, lo};
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");

    // Scan A: counting pattern, ready held high, aborted by reset at byte 1000.
    load_expect();
    @(posedge clk); #1;
    start = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    check("busy_in_start_cycle", 32'(busy), 0);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      @(negedge clk);
      if (lat == 1) check("busy_after_start", 32'(busy), 1);
      got = pix_valid;
    end
    check("first_valid_latency", lat, 3);

    cyc = 0;
    while (hs_count < 1000 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_byte_1000", 32'(hs_count >= 1000), 1);
    dc = done_count;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_scan_reset");
    repeat (20) @(negedge clk);
    check("no_done_after_reset", done_count, dc);
    check("idle_after_reset_cs_n", 32'(cs_n), 1);

    // Scan B: random frame, random ready for the first 3000 bytes, ignored restart at byte 500.
    exp_sum = 32'd0;
    for (int i = 0; i < FRAME_WORDS; i++) begin
      w = $urandom();
      mem[i] = w;
      exp_sum = exp_sum + w[7:0] + w[15:8] + w[23:16] + w[31:24];
    end
    load_expect();
    @(posedge clk); #1;
    start = 1'b1;
    restart_sent = 1'b0;
    cyc = 0;
    while (done_count == dc && cyc < 80000) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (!restart_sent && hs_count >= 500) begin
        start = 1'b1;
        restart_sent = 1'b1;
      end
      pix_ready = (hs_count < 3000) ? 1'($urandom_range(0, 1)) : 1'b1;
      tp_mode = (hs_count >= 3100);
    end
    start = 1'b0;
    tp_mode = 1'b0;
    check("done_seen", done_count, dc + 1);
    @(negedge clk);
    check("done_single_cycle", 32'(done), 0);
    check("busy_after_done", 32'(busy), 0);
    check("byte_total", hs_count, FRAME_BYTES);
    check("words_issued", issued, FRAME_WORDS);
    check("eof_count", eof_count, 1);
    check("scoreboard_drained", sb_q.size(), 0);
    check("y_sol_count", sol_cnt[0], 144);
    check("cb_sol_count", sol_cnt[1], 72);
    check("cr_sol_count", sol_cnt[2], 72);
    check("cb_first_byte", first_idx[1], 25344);
    check("cr_first_byte", first_idx[2], 31680);
    check("no_bubbles_ready_high", bubbles, 0);
`ifdef DISPLAY_CHECKSUM_EN
    check("checksum_at_done", done_ck, exp_sum);
`else
    check("checksum_at_done", done_ck, 32'd0);
`endif
    repeat (20) @(negedge clk);
    check("single_done_total", done_count, dc + 1);
    check("idle_cs_n_after_frame", 32'(cs_n), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
